// File: rtl/iob_ahb2axis.sv
// AHB-Lite subordinate bridging full-word writes onto an output AXI-Stream
// and full-word reads from an input AXI-Stream, with a small status register.
module iob_ahb2axis #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    rst_i,

    input  logic [ADDR_WIDTH-1:0]   s_ahb_addr_i,
    input  logic [2:0]              s_ahb_burst_i,
    input  logic                    s_ahb_mastlock_i,
    input  logic [3:0]              s_ahb_prot_i,
    input  logic [2:0]              s_ahb_size_i,
    input  logic [1:0]              s_ahb_trans_i,
    input  logic                    s_ahb_write_i,
    input  logic [DATA_WIDTH-1:0]   s_ahb_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_ahb_wstrb_i,
    input  logic                    s_ahb_sel_i,
    output logic [DATA_WIDTH-1:0]   s_ahb_rdata_o,
    output logic                    s_ahb_readyout_o,
    output logic                    s_ahb_resp_o,

    output logic                    out_axis_tvalid_o,
    input  logic                    out_axis_tready_i,
    output logic [DATA_WIDTH-1:0]   out_axis_tdata_o,
    output logic                    out_axis_tlast_o,

    input  logic                    in_axis_tvalid_i,
    output logic                    in_axis_tready_o,
    input  logic [DATA_WIDTH-1:0]   in_axis_tdata_i,
    input  logic                    in_axis_tlast_i
);

    localparam logic [1:0] WordData     = 2'd0;
    localparam logic [1:0] WordDataLast = 2'd1;
    localparam logic [1:0] WordStatus   = 2'd2;
    localparam logic [1:0] WordInvalid  = 2'd3;

    typedef enum logic [2:0] {StIdle, StWr, StRd, StErr1, StErr2} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              word_q, word_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

    logic [1:0]              addr_word;
    logic                    accept;
    logic                    err_cond;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   status_word;

    logic unused_inputs;
    assign unused_inputs = ^{s_ahb_burst_i, s_ahb_mastlock_i, s_ahb_prot_i, s_ahb_wstrb_i,
                             s_ahb_addr_i[ADDR_WIDTH-1:4], s_ahb_addr_i[1:0]};

    assign addr_word   = s_ahb_addr_i[3:2];
    assign accept      = s_ahb_sel_i & s_ahb_trans_i[1] & s_ahb_readyout_o;
    assign err_cond    = (s_ahb_size_i != 3'd2) || (addr_word == WordInvalid) ||
                         (s_ahb_write_i && addr_word == WordStatus) ||
                         (!s_ahb_write_i && addr_word == WordDataLast);
    assign status_word = {{(DATA_WIDTH-3){1'b0}}, in_axis_tlast_i, in_axis_tvalid_i,
                          ~out_valid_q};

    assign out_axis_tvalid_o = out_valid_q;
    assign out_axis_tdata_o  = out_data_q;
    assign out_axis_tlast_o  = out_last_q;

    // Data-phase response and stream handshakes, decoded from the current state.
    always_comb begin
        s_ahb_readyout_o = 1'b1;
        s_ahb_resp_o     = 1'b0;
        s_ahb_rdata_o    = '0;
        in_axis_tready_o = 1'b0;
        capture          = 1'b0;
        unique case (state_q)
            StWr: begin
                // Space exists if empty or the held word leaves this same cycle.
                s_ahb_readyout_o = ~out_valid_q | out_axis_tready_i;
                capture          = s_ahb_readyout_o;
            end
            StRd: begin
                if (word_q == WordData) begin
                    s_ahb_readyout_o = in_axis_tvalid_i;
                    in_axis_tready_o = in_axis_tvalid_i;
                    if (in_axis_tvalid_i) begin
                        s_ahb_rdata_o = in_axis_tdata_i;
                    end
                end else begin
                    s_ahb_rdata_o = status_word;
                end
            end
            StErr1: begin
                s_ahb_readyout_o = 1'b0;
                s_ahb_resp_o     = 1'b1;
            end
            StErr2: begin
                s_ahb_resp_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        if (state_q == StErr1) begin
            state_d = StErr2;
        end else if (accept) begin
            word_d = addr_word;
            if (err_cond) begin
                state_d = StErr1;
            end else if (s_ahb_write_i) begin
                state_d = StWr;
            end else begin
                state_d = StRd;
            end
        end else if (s_ahb_readyout_o) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (capture) begin
            out_valid_d = 1'b1;
            out_last_d  = (word_q == WordDataLast);
            out_data_d  = s_ahb_wdata_i;
        end else if (out_valid_q && out_axis_tready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            word_q      <= WordData;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (cke_i) begin
            state_q     <= state_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_iob_ahb2axis.sv
// Self-checking bench for iob_ahb2axis: vector table of single transfers plus
// hand-written pipelined, stalled-read, reset and clock-enable sequences.
module tb_iob_ahb2axis;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          cke = 1'b1;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [2:0]    burst = '0;
    logic          mastlock = 1'b0;
    logic [3:0]    prot = '0;
    logic [2:0]    size = 3'd2;
    logic [1:0]    trans = 2'b00;
    logic          write = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = 4'hF;
    logic          sel = 1'b0;
    logic [DW-1:0] rdata;
    logic          readyout;
    logic          resp;
    logic          out_tvalid;
    logic          out_tready = 1'b1;
    logic [DW-1:0] out_tdata;
    logic          out_tlast;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [DW-1:0] in_tdata = '0;
    logic          in_tlast = 1'b0;

    iob_ahb2axis #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i            (clk),
        .cke_i            (cke),
        .rst_i            (rst),
        .s_ahb_addr_i     (addr),
        .s_ahb_burst_i    (burst),
        .s_ahb_mastlock_i (mastlock),
        .s_ahb_prot_i     (prot),
        .s_ahb_size_i     (size),
        .s_ahb_trans_i    (trans),
        .s_ahb_write_i    (write),
        .s_ahb_wdata_i    (wdata),
        .s_ahb_wstrb_i    (wstrb),
        .s_ahb_sel_i      (sel),
        .s_ahb_rdata_o    (rdata),
        .s_ahb_readyout_o (readyout),
        .s_ahb_resp_o     (resp),
        .out_axis_tvalid_o(out_tvalid),
        .out_axis_tready_i(out_tready),
        .out_axis_tdata_o (out_tdata),
        .out_axis_tlast_o (out_tlast),
        .in_axis_tvalid_i (in_tvalid),
        .in_axis_tready_o (in_tready),
        .in_axis_tdata_i  (in_tdata),
        .in_axis_tlast_i  (in_tlast)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int in_pops = 0;
    logic [DW:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every emitted beat must match the oldest expected {last, data}.
    always @(posedge clk) begin
        if (!rst && cke) begin
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got 0x%0h last %0b, expected none",
                             out_tdata, out_tlast);
                end else begin
                    check("out_beat", 64'({out_tlast, out_tdata}), 64'(exp_q.pop_front()));
                end
            end
            if (in_tvalid && in_tready) in_pops++;
        end
    end

    task automatic ahb_xfer(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz,
                            input logic [DW-1:0] wd, output int waits, output logic first_resp,
                            output logic last_resp, output logic [DW-1:0] rd);
        @(negedge clk);
        sel = 1'b1; trans = 2'b10; write = wr; addr = a; size = sz;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; trans = 2'b00; wdata = wd;
        #1;
        waits = 0;
        first_resp = resp;
        while (!readyout && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        last_resp = resp;
        rd = rdata;
        @(posedge clk);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [DW-1:0] wdata;
        logic          in_valid;
        logic          in_last;
        logic [DW-1:0] in_data;
        int            exp_waits;
        logic          exp_resp;
        logic [DW-1:0] exp_rdata;
        logic          exp_beat;
        logic          exp_last;
        logic          exp_pop;
    } vec_t;

    vec_t vecs[12];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        logic r1, r2;
        logic [DW-1:0] rd;
        int pops0;

        //         wr    addr     size  wdata        inv   inl   indata       wt rsp rdata        beat last pop
        vecs[0]  = '{1'b1, 10'h000, 3'd2, 32'h11,      1'b0, 1'b0, 32'h0,       0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 10'h000, 3'd2, 32'h22,      1'b0, 1'b0, 32'h0,       0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 10'h004, 3'd2, 32'h33,      1'b0, 1'b0, 32'h0,       0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 10'h008, 3'd2, 32'h0,       1'b1, 1'b1, 32'h5A5A,    0, 1'b0, 32'h7,       1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 10'h000, 3'd2, 32'h0,       1'b1, 1'b0, 32'h12345678, 0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 10'h008, 3'd2, 32'h0,       1'b0, 1'b0, 32'h0,       0, 1'b0, 32'h1,       1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 10'h00C, 3'd2, 32'h66,      1'b0, 1'b0, 32'h0,       1, 1'b1, 32'h0,       1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 10'h000, 3'd0, 32'h77,      1'b0, 1'b0, 32'h0,       1, 1'b1, 32'h0,       1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 10'h008, 3'd2, 32'h88,      1'b0, 1'b0, 32'h0,       1, 1'b1, 32'h0,       1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 10'h004, 3'd2, 32'h0,       1'b1, 1'b0, 32'h99,      1, 1'b1, 32'h0,       1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 10'h000, 3'd1, 32'h0,       1'b1, 1'b0, 32'hAA,      1, 1'b1, 32'h0,       1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 10'h3F0, 3'd2, 32'h55,      1'b0, 1'b0, 32'h0,       0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_readyout", 64'(readyout), 64'd1);
        check("rst_resp", 64'(resp), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_tlast", 64'(out_tlast), 64'd0);
        check("rst_tdata", 64'(out_tdata), 64'd0);
        check("rst_in_tready", 64'(in_tready), 64'd0);

        // Single transfers against a free-running sink.
        out_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_tvalid = vecs[i].in_valid;
            in_tlast  = vecs[i].in_last;
            in_tdata  = vecs[i].in_data;
            pops0 = in_pops;
            if (vecs[i].exp_beat) exp_q.push_back({vecs[i].exp_last, vecs[i].wdata});
            ahb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, w, r1, r2, rd);
            @(negedge clk);
            check($sformatf("v%0d_waits", i), 64'(w), 64'(vecs[i].exp_waits));
            check($sformatf("v%0d_resp_first", i), 64'(r1), 64'(vecs[i].exp_resp));
            check($sformatf("v%0d_resp", i), 64'(r2), 64'(vecs[i].exp_resp));
            check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            check($sformatf("v%0d_pops", i), 64'(in_pops - pops0), 64'(vecs[i].exp_pop));
            in_tvalid = 1'b0;
            in_tlast  = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("tbl_drained", 64'(exp_q.size()), 64'd0);

        // Back-to-back writes into a stalled sink.
        out_tready = 1'b0;
        exp_q.push_back({1'b0, 32'hA0A0_0001});
        exp_q.push_back({1'b0, 32'hB0B0_0002});
        @(negedge clk);
        sel = 1'b1; trans = 2'b10; write = 1'b1; addr = 10'h000; size = 3'd2;
        @(posedge clk);
        @(negedge clk);
        wdata = 32'hA0A0_0001;
        #1;
        check("b2b_a_ready", 64'(readyout), 64'd1);
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; trans = 2'b00; wdata = 32'hB0B0_0002;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("b2b_b_stall", 64'(readyout), 64'd0);
            check("b2b_a_held", 64'({out_tvalid, out_tdata}), 64'({1'b1, 32'hA0A0_0001}));
            @(negedge clk);
            #1;
        end
        out_tready = 1'b1;
        #1;
        check("b2b_b_ready", 64'(readyout), 64'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("b2b_b_held", 64'({out_tvalid, out_tdata}), 64'({1'b1, 32'hB0B0_0002}));
        @(posedge clk);
        @(negedge clk);
        #1;
        check("b2b_drained", 64'(exp_q.size()), 64'd0);
        check("b2b_tvalid", 64'(out_tvalid), 64'd0);

        // Read of DATA with an empty input stream for five cycles.
        pops0 = in_pops;
        in_tvalid = 1'b0;
        @(negedge clk);
        sel = 1'b1; trans = 2'b10; write = 1'b0; addr = 10'h000; size = 3'd2;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; trans = 2'b00;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("rdw_ready", 64'(readyout), 64'd0);
            check("rdw_in_tready", 64'(in_tready), 64'd0);
            check("rdw_rdata", 64'(rdata), 64'd0);
            @(negedge clk);
            #1;
        end
        in_tvalid = 1'b1; in_tdata = 32'h0000_CAFE;
        #1;
        check("rdw_done_ready", 64'(readyout), 64'd1);
        check("rdw_done_rdata", 64'(rdata), 64'h0000_CAFE);
        @(posedge clk);
        @(negedge clk);
        in_tvalid = 1'b0;
        #1;
        check("rdw_pops", 64'(in_pops - pops0), 64'd1);
        check("rdw_in_tready_after", 64'(in_tready), 64'd0);

        // Clock enable low freezes the holding register.
        out_tready = 1'b0;
        exp_q.push_back({1'b0, 32'h0000_BEEF});
        ahb_xfer(1'b1, 10'h000, 3'd2, 32'h0000_BEEF, w, r1, r2, rd);
        @(negedge clk);
        cke = 1'b0;
        out_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("cke_hold", 64'({out_tvalid, out_tdata}), 64'({1'b1, 32'h0000_BEEF}));
        end
        cke = 1'b1;
        @(negedge clk);
        #1;
        check("cke_resume", 64'(out_tvalid), 64'd0);
        check("cke_drained", 64'(exp_q.size()), 64'd0);

        // Reset while a word is stranded in the holding register.
        out_tready = 1'b0;
        ahb_xfer(1'b1, 10'h000, 3'd2, 32'h0000_DEAD, w, r1, r2, rd);
        check("rstf_waits", 64'(w), 64'd0);
        @(negedge clk);
        #1;
        check("rstf_full", 64'(out_tvalid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstf_tvalid", 64'(out_tvalid), 64'd0);
        check("rstf_readyout", 64'(readyout), 64'd1);
        check("rstf_tdata", 64'(out_tdata), 64'd0);
        rst = 1'b0;
        out_tready = 1'b1;
        repeat (4) @(negedge clk);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
